// File: rtl/regfile_master.sv
// Command sequencer for an external register file with two async read ports and one write port.
// Define REGFILE_MASTER_CLEAR_EN to build in the sequential CLEAR of every register.
module regfile_master #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addra,
    input  logic [AW-1:0] cmd_addrb,
    input  logic [AW-1:0] cmd_addrc,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_dataa,
    output logic [DW-1:0] rsp_datab,
    output logic [AW-1:0] addra,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] dataa,
    input  logic [DW-1:0] datab,
    output logic          enc,
    output logic [AW-1:0] addrc,
    output logic [DW-1:0] datac,
    output logic          busy
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

`ifdef REGFILE_MASTER_CLEAR_EN
    localparam logic [DW-1:0] NREGS = DW'(2**AW);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_COPY1,
        S_COPY2,
`ifdef REGFILE_MASTER_CLEAR_EN
        S_CLEAR,
`endif
        S_RESP
    } state_t;

    state_t        state;
    logic [AW-1:0] dst_q;

    // All outputs are registered; the read/write port addresses double as the latched command fields.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dataa <= '0;
            rsp_datab <= '0;
            addra     <= '0;
            addrb     <= '0;
            addrc     <= '0;
            datac     <= '0;
            enc       <= 1'b0;
            dst_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        dst_q     <= cmd_addrc;
                        case (cmd_op)
                            OP_READ: begin
                                addra <= cmd_addra;
                                addrb <= cmd_addrb;
                                state <= S_READ;
                            end
                            OP_WRITE: begin
                                enc   <= 1'b1;
                                addrc <= cmd_addrc;
                                datac <= cmd_data;
                                state <= S_WRITE;
                            end
                            OP_COPY: begin
                                addra <= cmd_addra;
                                state <= S_COPY1;
                            end
                            default: begin
`ifdef REGFILE_MASTER_CLEAR_EN
                                enc   <= 1'b1;
                                addrc <= '0;
                                datac <= '0;
                                state <= S_CLEAR;
`else
                                // No clear hardware: answer immediately with the error marker.
                                rsp_dataa <= '0;
                                rsp_datab <= '1;
                                rsp_valid <= 1'b1;
                                state     <= S_RESP;
`endif
                            end
                        endcase
                    end
                end
                S_READ: begin
                    rsp_dataa <= dataa;
                    rsp_datab <= datab;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_WRITE: begin
                    enc       <= 1'b0;
                    rsp_dataa <= datac;
                    rsp_datab <= '0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_COPY1: begin
                    enc   <= 1'b1;
                    addrc <= dst_q;
                    datac <= dataa;
                    state <= S_COPY2;
                end
                S_COPY2: begin
                    enc       <= 1'b0;
                    rsp_dataa <= datac;
                    rsp_datab <= '0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
`ifdef REGFILE_MASTER_CLEAR_EN
                S_CLEAR: begin
                    // addrc itself is the sweep counter; the last address ends the sweep.
                    if (addrc == {AW{1'b1}}) begin
                        enc       <= 1'b0;
                        rsp_dataa <= NREGS;
                        rsp_datab <= '0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        addrc <= addrc + AW'(1);
                    end
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_master.sv
// Randomized bench for regfile_master: behavioural register file plus command-level reference model.
module tb_regfile_master;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;
`ifdef REGFILE_MASTER_CLEAR_EN
    localparam bit CLR_ON = 1'b1;
`else
    localparam bit CLR_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addra = '0, cmd_addrb = '0, cmd_addrc = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dataa, rsp_datab;
    logic [AW-1:0] addra, addrb, addrc;
    logic [DW-1:0] dataa, datab, datac;
    logic          enc, busy;

    logic [DW-1:0] rf  [NREG] = '{default: '0};
    logic [DW-1:0] mdl [NREG] = '{default: '0};
    int            enc_log [$];
    int            cyc = 0, enc_cnt = 0, acc_cnt = 0, rsp_cnt = 0;
    int            n_tests = 0, n_fail = 0;

    regfile_master #(.DW(DW), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addra(cmd_addra), .cmd_addrb(cmd_addrb), .cmd_addrc(cmd_addrc), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dataa(rsp_dataa), .rsp_datab(rsp_datab),
        .addra(addra), .addrb(addrb), .dataa(dataa), .datab(datab),
        .enc(enc), .addrc(addrc), .datac(datac), .busy(busy)
    );

    always #5 clock = ~clock;

    assign dataa = rf[addra];
    assign datab = rf[addrb];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset && enc) begin
            rf[addrc] <= datac;
            enc_cnt   <= enc_cnt + 1;
            enc_log.push_back(int'(addrc));
        end
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
        if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rf(input string tag);
        int bad = 0;
        for (int i = 0; i < NREG; i++) if (rf[i] !== mdl[i]) bad++;
        chk(tag, 64'(bad), 64'd0);
    endtask

    task automatic do_cmd(input logic [1:0] op, input int a, input int b, input int c,
                          input logic [DW-1:0] d, input int hold);
        logic [DW-1:0] ea, eb, pa, pb, v;
        int  eenc, elat, e0, l0, acc, bad;
        bit  ok;
        string nm;
        nm = $sformatf("op%0d", op);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin chk({nm, "_ready_timeout"}, 64'd0, 64'd1); return; end
        case (op)
            2'd0: begin ea = mdl[a]; eb = mdl[b]; eenc = 0; elat = 1; end
            2'd1: begin ea = d; eb = '0; eenc = 1; elat = 1; end
            2'd2: begin ea = mdl[a]; eb = '0; eenc = 1; elat = 2; end
            default: begin
                if (CLR_ON) begin ea = DW'(NREG); eb = '0; eenc = NREG; elat = NREG; end
                else begin ea = '0; eb = '1; eenc = 0; elat = 0; end
            end
        endcase
        e0 = enc_cnt;
        l0 = enc_log.size();
        cmd_valid = 1'b1; cmd_op = op;
        cmd_addra = AW'(a); cmd_addrb = AW'(b); cmd_addrc = AW'(c); cmd_data = d;
        @(posedge clock); #1;
        acc = cyc;
        cmd_valid = 1'b0; cmd_data = $urandom; cmd_addra = AW'($urandom);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) begin chk({nm, "_rsp_timeout"}, 64'd0, 64'd1); return; end
        chk({nm, "_latency"}, 64'(cyc - acc), 64'(elat));
        chk({nm, "_rsp_dataa"}, 64'(rsp_dataa), 64'(ea));
        chk({nm, "_rsp_datab"}, 64'(rsp_datab), 64'(eb));
        chk({nm, "_enc_cycles"}, 64'(enc_cnt - e0), 64'(eenc));
        bad = 0;
        if (op == 2'd1 || op == 2'd2) begin
            if (enc_log.size() != l0 + 1 || enc_log[l0] != c) bad++;
        end else if (op == 2'd3 && CLR_ON) begin
            for (int i = 0; i < NREG; i++) if (l0 + i >= enc_log.size() || enc_log[l0 + i] != i) bad++;
        end
        chk({nm, "_write_addrs"}, 64'(bad), 64'd0);
        // Reference model update at command granularity.
        case (op)
            2'd1: mdl[c] = d;
            2'd2: begin v = mdl[a]; mdl[c] = v; end
            2'd3: if (CLR_ON) for (int i = 0; i < NREG; i++) mdl[i] = '0;
            default: ;
        endcase
        pa = rsp_dataa; pb = rsp_datab;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addrc = AW'($urandom);
        bad = 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_dataa !== pa || rsp_datab !== pb || cmd_ready || !busy) bad++;
        end
        if (hold > 0) chk({nm, "_hold_stable"}, 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge clock);
        chk({nm, "_post_rsp_rdy_vld_busy"}, {61'd0, cmd_ready, rsp_valid, busy}, 64'b100);
        chk_rf({nm, "_regfile"});
    endtask

    initial begin
        int a0, r0, e0;
        #1;
        chk("reset_ctrl", {59'd0, cmd_ready, busy, enc, rsp_valid, 1'b0}, 64'd0);
        chk("reset_regs", {addra, addrb, addrc, datac[15:0]}, 64'd0);
        chk("reset_payload", {rsp_dataa, rsp_datab}, 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        #1 chk("ready_before_edge", 64'(cmd_ready), 64'd0);
        @(posedge clock); #1;
        chk("ready_after_release", 64'(cmd_ready), 64'd1);

        do_cmd(2'd1, 0, 0, 7, 32'hDEADBEEF, 0);
        do_cmd(2'd0, 7, 0, 0, 32'h0, 0);
        do_cmd(2'd1, 0, 0, 3, 32'h12345678, 0);
        do_cmd(2'd2, 3, 0, 9, 32'h0, 0);
        do_cmd(2'd0, 9, 3, 0, 32'h0, 5);
        do_cmd(2'd2, 9, 0, 9, 32'h0, 1);
        do_cmd(2'd1, 0, 0, 0, 32'hA5A5A5A5, 0);
        do_cmd(2'd0, 0, 31, 0, 32'h0, 0);

        // Reset in the first COPY cycle: nothing may be written or answered.
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addra = 5'd7; cmd_addrc = 5'd12;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        e0 = enc_cnt;
        reset = 1'b0;
        #1 chk("midcopy_reset_outs", {60'd0, enc, rsp_valid, busy, cmd_ready}, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        chk("midcopy_no_write", 64'(enc_cnt - e0), 64'd0);
        @(posedge clock); #1;
        chk("midcopy_ready_rv", {62'd0, cmd_ready, rsp_valid}, 64'b10);
        chk_rf("midcopy_regfile");

        for (int i = 0; i < NREG; i++) do_cmd(2'd1, 0, 0, i, 32'hFFFFFFFF, 0);
        do_cmd(2'd3, 0, 0, 0, 32'h0, 2);
        for (int i = 0; i < NREG; i += 2) do_cmd(2'd0, i, i + 1, 0, 32'h0, 0);

        for (int n = 0; n < 60; n++)
            do_cmd(2'($urandom_range(0, (n % 20 == 19) ? 3 : 2)), $urandom_range(0, NREG - 1),
                   $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1), $urandom,
                   $urandom_range(0, 3));

        // Back-to-back reads with the response side always ready.
        @(negedge clock);
        a0 = acc_cnt; r0 = rsp_cnt;
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0;
        repeat (30) begin
            @(negedge clock);
            cmd_addra = AW'($urandom); cmd_addrb = AW'($urandom);
        end
        cmd_valid = 1'b0;
        repeat (6) @(negedge clock);
        rsp_ready = 1'b0;
        chk("b2b_accepts", 64'(acc_cnt - a0), 64'd10);
        chk("b2b_responses", 64'(rsp_cnt - r0), 64'(acc_cnt - a0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_master.md
REGFILE_MASTER -- requirements
Module: regfile_master

Interface
REQ-001 SHALL have parameter DW, default 32, register data width.
REQ-002 SHALL have parameter AW, default 5, register address width (2^AW registers).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  block accepts a command; a transfer occurs on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-007 cmd_op  input  2  operation: 00 READ, 01 WRITE, 10 COPY, 11 CLEAR.
REQ-008 cmd_addra, cmd_addrb, cmd_addrc  input  AW each  source A, source B, destination.
REQ-009 cmd_data  input  DW  write data.
REQ-010 rsp_valid  output  1  response held.
REQ-011 rsp_ready  input  1  response consumed on a rising edge with rsp_valid=1.
REQ-012 rsp_dataa, rsp_datab  output  DW each  response payload.
REQ-013 addra, addrb  output  AW each  register-file read addresses (asynchronous read ports).
REQ-014 dataa, datab  input  DW each  register-file read data.
REQ-015 enc, addrc, datac  output  1/AW/DW  register-file write port; write occurs on a rising edge with enc=1.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, COPY, CLEAR, RESP; cmd_ready=1 only in IDLE.
REQ-018 On accept SHALL latch all cmd_* fields and go to READ/WRITE/COPY/CLEAR per cmd_op.
REQ-019 READ: one cycle driving addra/addrb from latched addresses; SHALL capture dataa->rsp_dataa, datab->rsp_datab at the end of that cycle; then RESP.
REQ-020 WRITE: one cycle with enc=1, addrc/datac from latched values; rsp_dataa=written data, rsp_datab=0; then RESP.
REQ-021 COPY: first cycle drives addra=src A and captures dataa; second cycle enc=1, addrc=dest, datac=captured value; rsp_dataa=copied value, rsp_datab=0; then RESP.
REQ-022 RESP: rsp_valid=1 with stable payload until rsp_ready=1, then IDLE; cmd_ready SHALL stay 0 until the cycle after the response transfer.
REQ-023 Latency: accept at edge N -> rsp_valid high from cycle after edge N+1 (READ/WRITE) or N+2 (COPY).
REQ-024 enc SHALL be 0 in all states other than WRITE, the second COPY cycle, and CLEAR.
REQ-025 addra/addrb/addrc/datac SHALL hold their last value when unused; no other output toggles in IDLE.
REQ-026 COPY with src A = dest SHALL still perform the write (value unchanged).
REQ-027 Write to any address, including 0, SHALL be issued; register-file handling of address 0 is outside this block.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, enc=0, rsp_valid=0, busy=0, cmd_ready=0, all address/data/payload registers 0.
REQ-029 cmd_ready SHALL rise on the first rising edge after reset deasserts.
REQ-030 reset mid-operation SHALL abandon the command with no further write and no response.

Configuration
REQ-031 Macro REGFILE_MASTER_CLEAR_EN compiles in the CLEAR sequence.
REQ-032 With it: CLEAR writes 0 to addresses 0..2^AW-1 in ascending order, one per cycle, enc=1 for exactly 2^AW consecutive cycles; then RESP with rsp_dataa=2^AW, rsp_datab=0.
REQ-033 Without it: CLEAR goes directly to RESP with no write, rsp_dataa=0, rsp_datab={DW{1}} (error marker); no CLEAR state or counter logic exists.

Verification
REQ-034 WRITE addr 7 data 0xDEADBEEF, then READ a=7 b=0 -> rsp_dataa=0xDEADBEEF, enc high exactly one cycle.
REQ-035 WRITE r3=0x12345678, COPY a=3 c=9, READ a=9 -> rsp_dataa=0x12345678, COPY rsp one cycle later than READ rsp.
REQ-036 READ with rsp_ready low 5 cycles -> rsp_valid/payload stable 5 cycles, cmd_ready=0 throughout, cmd_valid ignored.
REQ-037 reset pulled low during COPY first cycle -> enc never asserts, rsp_valid=0, cmd_ready=1 one edge after release.
REQ-038 CLEAR after writing 0xFFFFFFFF to all registers -> macro on: 32 enc cycles, all reads 0, rsp_dataa=32; macro off: no enc, rsp_datab=0xFFFFFFFF.
REQ-039 Back-to-back cmd_valid with rsp_ready=1 -> one command per response, none dropped or duplicated.
